drum_div_seq: RTL and testbench

- Sequential approximate unsigned divider; the divide-side counterpart of the DRUM dynamic-range multiplier in the approximate-arithmetic library.
- Each operand is reduced to a K-bit unbiased window at its leading one, using the same rule as the multiplier.
- A 2K-bit restoring divider computes the window quotient one bit per clock, and a final signed shift restores the magnitude.
- Uses valid/ready handshakes on input and output, so it can drop into the same datapaths as the multiplier.

---
 rtl/drum_div_pkg.sv | 18 +
 rtl/drum_div_lod_trunc.sv | 30 +++
 rtl/drum_div_seq.sv | 149 ++++++++++++++
 tb/tb_drum_div_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/drum_div_pkg.sv
// Shared types and default widths for the DRUM approximate sequential divider.
package drum_div_pkg;

  localparam int unsigned DRUM_N     = 16;
  localparam int unsigned DRUM_K     = 6;
  localparam int unsigned DRUM_LOG2N = $clog2(DRUM_N);
  localparam int unsigned DRUM_SW    = DRUM_LOG2N + 2;
  localparam int unsigned DRUM_QW    = 2 * DRUM_K;

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StDiv,
    StShift,
    StOut
  } state_e;

endpackage

// File: rtl/drum_div_lod_trunc.sv
// Leading-one detect and K-bit unbiased window extraction for one operand.
module drum_div_lod_trunc
  import drum_div_pkg::*;
#(
  parameter int unsigned N     = DRUM_N,
  parameter int unsigned K     = DRUM_K,
  parameter int unsigned LOG2N = $clog2(N)
) (
  input  logic [N-1:0]     x,
  output logic [K-1:0]     m,
  output logic [LOG2N-1:0] p
);

  logic [LOG2N-1:0] kx;

  always_comb begin
    kx = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) kx = LOG2N'(i);
    end
    m = x[K-1:0];
    p = '0;
    // Wide operand: keep top K-1 bits below the leading one, force LSB to 1 to cancel bias
    if (kx > LOG2N'(K - 1)) begin
      p = kx - LOG2N'(K - 1);
      m = K'(x >> p) | K'(1);
    end
  end

endmodule

// File: rtl/drum_div_seq.sv
// DRUM-style approximate unsigned divider: window both operands, restoring-divide the
// windows one quotient bit per clock, then shift the window quotient back to full scale.
module drum_div_seq
  import drum_div_pkg::*;
#(
  parameter int unsigned N = DRUM_N,
  parameter int unsigned K = DRUM_K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         div_by_zero
);

  localparam int unsigned LOG2N = $clog2(N);
  localparam int unsigned SW    = LOG2N + 2;
  localparam int unsigned QW    = 2 * K;
  localparam int unsigned CW    = $clog2(QW);

  state_e state_q, state_d;

  logic [N-1:0]     a_q, b_q;
  logic [QW-1:0]    num_q;
  logic [K:0]       rem_q;
  logic [K-1:0]     mb_q;
  logic [LOG2N-1:0] pa_q, pb_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     q_q;
  logic             dbz_q;

  logic [K-1:0]     ma, mb;
  logic [LOG2N-1:0] pa, pb;

  drum_div_lod_trunc #(.N(N), .K(K), .LOG2N(LOG2N)) u_lod_a (
    .x (a_q),
    .m (ma),
    .p (pa)
  );

  drum_div_lod_trunc #(.N(N), .K(K), .LOG2N(LOG2N)) u_lod_b (
    .x (b_q),
    .m (mb),
    .p (pb)
  );

  // Restoring division step
  logic [K+1:0] rem_sh;
  logic         fits;
  logic [K:0]   rem_nx;

  always_comb begin
    rem_sh = {rem_q, num_q[QW-1]};
    fits   = rem_sh >= (K+2)'(mb_q);
    rem_nx = fits ? (K+1)'(rem_sh - (K+2)'(mb_q)) : rem_sh[K:0];
  end

  // Final rescale: s = pa - pb - K in two's complement, sign picks shift direction
  logic [SW-1:0]   s;
  logic [SW-1:0]   shamt;
  logic [N+QW-1:0] wide;
  logic [N+QW-1:0] shifted;
  logic [N-1:0]    q_sat;

  always_comb begin
    s       = SW'(pa_q) - SW'(pb_q) - SW'(K);
    shamt   = s[SW-1] ? (~s + SW'(1)) : s;
    wide    = {{N{1'b0}}, num_q};
    shifted = s[SW-1] ? (wide >> shamt) : (wide << shamt);
    q_sat   = (|shifted[N+QW-1:N]) ? {N{1'b1}} : shifted[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StNorm;
      StNorm:  state_d = (b_q == '0) ? StOut : StDiv;
      StDiv:   if (cnt_q == '0) state_d = StShift;
      StShift: state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StOut);
    q           = q_q;
    div_by_zero = dbz_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      num_q <= '0;
      rem_q <= '0;
      mb_q  <= '0;
      pa_q  <= '0;
      pb_q  <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        StNorm: begin
          if (b_q == '0) begin
            q_q   <= {N{1'b1}};
            dbz_q <= 1'b1;
          end else begin
            num_q <= {ma, {K{1'b0}}};
            rem_q <= '0;
            mb_q  <= mb;
            pa_q  <= pa;
            pb_q  <= pb;
            cnt_q <= CW'(QW - 1);
          end
        end
        StDiv: begin
          rem_q <= rem_nx;
          num_q <= {num_q[QW-2:0], fits};
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        StShift: begin
          q_q   <= q_sat;
          dbz_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_div_seq.sv
// Self-checking bench for drum_div_seq: directed cases, backpressure, mid-op reset, random ops.
module tb_drum_div_seq;

  localparam int N = 16;
  localparam int K = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  q;
  logic          div_by_zero;

  int total = 0;
  int bad   = 0;

  drum_div_seq #(.N(N), .K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: window each operand, divide windows exactly, rescale by powers of two.
  function automatic void window(input int unsigned x, output int unsigned m, output int p);
    int msb;
    if (x < (1 << K)) begin
      m = x;
      p = 0;
    end else begin
      msb = $clog2(x + 1) - 1;
      p   = msb - (K - 1);
      m   = (x >> p) | 1;
    end
  endfunction

  function automatic logic [N:0] model(input int unsigned xa, input int unsigned xb);
    int unsigned ma, mb;
    int          pa, pb, s;
    longint      quot, r;
    logic [63:0] rv;
    if (xb == 0) return {1'b1, {N{1'b1}}};
    window(xa, ma, pa);
    window(xb, mb, pb);
    quot = (longint'(ma) << K) / longint'(mb);
    s    = pa - pb - K;
    r    = (s >= 0) ? (quot << s) : (quot >> (-s));
    if (r > ((longint'(1) << N) - 1)) r = (longint'(1) << N) - 1;
    rv = r;
    return {1'b0, rv[N-1:0]};
  endfunction

  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb_);
    @(negedge clk);
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_cleared", out_valid, 0);
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                       input logic [N-1:0] exp_q, input logic exp_dbz, input int stall);
    int lat;
    start_op(ta, tb_);
    wait_out(lat);
    check({tag, "_q"}, q, exp_q);
    check({tag, "_dbz"}, div_by_zero, exp_dbz);
    check({tag, "_lat"}, lat, exp_dbz ? 2 : 2 * K + 3);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_q"}, q, exp_q);
      check({tag, "_hold_ready"}, in_ready, 0);
    end
    release_out();
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [N:0]  m;
    logic [N-1:0] ra, rb;

    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    out_ready = 1'b1;
    do_op("d100_7", 16'd100, 16'd7, 16'd14, 1'b0, 0);
    out_ready = 1'b0;
    do_op("d1000_10", 16'd1000, 16'd10, 16'd100, 1'b0, 0);
    do_op("d20_3", 16'd20, 16'd3, 16'd6, 1'b0, 0);
    do_op("dffff_1", 16'hFFFF, 16'd1, 16'hFC00, 1'b0, 0);
    do_op("d0_9", 16'd0, 16'd9, 16'd0, 1'b0, 0);
    do_op("d5_0", 16'd5, 16'd0, 16'hFFFF, 1'b1, 0);
    do_op("d20_3b", 16'd20, 16'd3, 16'd6, 1'b0, 0);

    // Backpressure with a new request waiting behind the held result
    start_op(16'd1000, 16'd10);
    wait_out(lat);
    check("bp_q", q, 100);
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'd20;
    b = 16'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_q", q, 100);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_released", out_valid, 0);
    check("bp_ready_after", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_taken", in_ready, 0);
    wait_out(lat);
    check("bp_next_q", q, 6);
    check("bp_next_lat", lat, 2 * K + 3);
    release_out();

    // Reset while dividing
    start_op(16'd100, 16'd7);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_q", q, 0);
    check("mrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_ready_after", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mrst_no_stale", seen, 0);
    do_op("mrst_next", 16'd1000, 16'd10, 16'd100, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      rb = N'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rb = '0;
      m = model(int'(ra), int'(rb));
      do_op("rnd", ra, rb, m[N-1:0], m[N], $urandom_range(0, 3));
      if (ra < (1 << K) && rb != 0 && rb < (1 << K)) begin
        check("rnd_exact", m[N-1:0], ra / rb);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
